// File: rtl/boundary_scan_register.sv
// JTAG boundary-scan data register: N_IN input cells and N_OUT output cells,
// each a capture/shift flop plus an update flop, with a 1-bit bypass path.
module boundary_scan_register #(
  parameter int unsigned N_IN  = 34,
  parameter int unsigned N_OUT = 17
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TDI,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
  input  logic [1:0]       Mode,
  input  logic [N_IN-1:0]  sys_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] sys_out,
  output logic             TDO
);

  localparam int unsigned L = N_IN + N_OUT;

  localparam logic [1:0] ModeNormal = 2'b00;
  localparam logic [1:0] ModeExtest = 2'b01;
  localparam logic [1:0] ModeIntest = 2'b10;
  localparam logic [1:0] ModeBypass = 2'b11;

  logic [L-1:0] sh_q, sh_d;
  logic [L-1:0] up_q, up_d;
  logic         byp_q, byp_d;

  logic is_bypass;
  logic is_extest;
  logic is_intest;

  assign is_bypass = (Mode == ModeBypass);
  assign is_extest = (Mode == ModeExtest);
  assign is_intest = (Mode == ModeIntest);

  // Capture/shift stage; frozen while bypassed so a mode excursion resumes cleanly.
  always_comb begin
    sh_d = sh_q;
    if (!is_bypass) begin
      if (CaptureDR) begin
        sh_d = {core_out, sys_in};
      end else if (ShiftDR) begin
        sh_d = {sh_q[L-2:0], TDI};
      end
    end
  end

  // Update stage holds in BYPASS so the pins stay clamped.
  always_comb begin
    up_d = up_q;
    if (UpdateDR && !is_bypass) begin
      up_d = sh_q;
    end
  end

  always_comb begin
    byp_d = byp_q;
    if (is_bypass) begin
      if (CaptureDR) begin
        byp_d = 1'b0;
      end else if (ShiftDR) begin
        byp_d = TDI;
      end
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      sh_q  <= '0;
      up_q  <= '0;
      byp_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      up_q  <= up_d;
      byp_q <= byp_d;
    end
  end

  // TDO comes only from flops, so there is no combinational TDI-to-TDO path.
  always_comb begin
    TDO = is_bypass ? byp_q : sh_q[L-1];
  end

  always_comb begin
    core_in = is_intest ? up_q[N_IN-1:0] : sys_in;
  end

  always_comb begin
    sys_out = (is_extest || is_bypass) ? up_q[L-1:N_IN] : core_out;
  end

  logic unused_mode;
  assign unused_mode = (Mode == ModeNormal);

endmodule

// File: tb/tb_boundary_scan_register.sv
// Directed bench for boundary_scan_register with a 4-input, 2-output chain.
module tb_boundary_scan_register;

  localparam int unsigned NIn  = 4;
  localparam int unsigned NOut = 2;

  logic            TCK;
  logic            TRST;
  logic            TDI;
  logic            CaptureDR;
  logic            ShiftDR;
  logic            UpdateDR;
  logic [1:0]      Mode;
  logic [NIn-1:0]  sys_in;
  logic [NIn-1:0]  core_in;
  logic [NOut-1:0] core_out;
  logic [NOut-1:0] sys_out;
  logic            TDO;

  int pass_cnt;
  int total_cnt;

  boundary_scan_register #(
    .N_IN (NIn),
    .N_OUT(NOut)
  ) dut (
    .TCK      (TCK),
    .TRST     (TRST),
    .TDI      (TDI),
    .CaptureDR(CaptureDR),
    .ShiftDR  (ShiftDR),
    .UpdateDR (UpdateDR),
    .Mode     (Mode),
    .sys_in   (sys_in),
    .core_in  (core_in),
    .core_out (core_out),
    .sys_out  (sys_out),
    .TDO      (TDO)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic test_reset();
    TRST = 1'b1; TDI = 1'b0; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
    Mode = 2'b00; sys_in = 4'hA; core_out = 2'b01;
    #2;
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL reset_tdo: got %b want 0", TDO);
    else pass_cnt++;
    tick();
    TRST = 1'b0;
    #1;
    total_cnt++;
    if (core_in !== 4'hA) $display("FAIL normal_core_in: got %h want a", core_in);
    else pass_cnt++;
    total_cnt++;
    if (sys_out !== 2'b01) $display("FAIL normal_sys_out: got %b want 01", sys_out);
    else pass_cnt++;
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL normal_tdo: got %b want 0", TDO);
    else pass_cnt++;
    Mode = 2'b01;
    #1;
    total_cnt++;
    if (sys_out !== 2'b00) $display("FAIL reset_up_out: got %b want 00", sys_out);
    else pass_cnt++;
    Mode = 2'b10;
    #1;
    total_cnt++;
    if (core_in !== 4'h0) $display("FAIL reset_up_in: got %h want 0", core_in);
    else pass_cnt++;
  endtask

  task automatic test_extest_shift();
    logic seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    Mode = 2'b01; sys_in = 4'h5; core_out = 2'b01;
    ShiftDR = 1'b1;
    for (int i = 0; i < 6; i++) begin
      TDI = seq[i];
      tick();
    end
    ShiftDR = 1'b0;
    TDI = 1'b0;
    total_cnt++;
    if (TDO !== 1'b1) $display("FAIL extest_tdo_first: got %b want 1", TDO);
    else pass_cnt++;
    total_cnt++;
    if (sys_out !== 2'b00) $display("FAIL extest_pre_update: got %b want 00", sys_out);
    else pass_cnt++;
    UpdateDR = 1'b1;
    tick();
    UpdateDR = 1'b0;
    total_cnt++;
    if (sys_out !== 2'b10) $display("FAIL extest_sys_out: got %b want 10", sys_out);
    else pass_cnt++;
    total_cnt++;
    if (core_in !== 4'h5) $display("FAIL extest_core_in: got %h want 5", core_in);
    else pass_cnt++;
    total_cnt++;
    if (TDO !== 1'b1) $display("FAIL extest_sh_hold: got %b want 1", TDO);
    else pass_cnt++;
  endtask

  task automatic test_capture_shift();
    logic exp_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    Mode = 2'b01; sys_in = 4'b0110; core_out = 2'b11;
    // Shift asserted alongside capture: capture must win.
    CaptureDR = 1'b1; ShiftDR = 1'b1; TDI = 1'b1;
    tick();
    CaptureDR = 1'b0; TDI = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (TDO !== exp_seq[i]) $display("FAIL capture_out_%0d: got %b want %b", i, TDO, exp_seq[i]);
      else pass_cnt++;
      tick();
    end
    ShiftDR = 1'b0;
    total_cnt++;
    if (sys_out !== 2'b10) $display("FAIL capture_up_hold: got %b want 10", sys_out);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic seq [3] = '{1'b1, 1'b1, 1'b0};
    Mode = 2'b11; sys_in = 4'h3; core_out = 2'b01;
    #1;
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL bypass_initial: got %b want 0", TDO);
    else pass_cnt++;
    ShiftDR = 1'b1; UpdateDR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      TDI = seq[i];
      tick();
      total_cnt++;
      if (TDO !== seq[i]) $display("FAIL bypass_tdo_%0d: got %b want %b", i, TDO, seq[i]);
      else pass_cnt++;
    end
    UpdateDR = 1'b0;
    total_cnt++;
    if (sys_out !== 2'b10) $display("FAIL bypass_clamp: got %b want 10", sys_out);
    else pass_cnt++;
    total_cnt++;
    if (core_in !== 4'h3) $display("FAIL bypass_core_in: got %h want 3", core_in);
    else pass_cnt++;
    TDI = 1'b1;
    tick();
    CaptureDR = 1'b1;
    tick();
    CaptureDR = 1'b0;
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL bypass_capture: got %b want 0", TDO);
    else pass_cnt++;
    // The chain held all zeros before bypass; it must still be zero.
    Mode = 2'b01; TDI = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (TDO !== 1'b0) $display("FAIL bypass_sh_hold_%0d: got %b want 0", i, TDO);
      else pass_cnt++;
      tick();
    end
    ShiftDR = 1'b0;
  endtask

  task automatic test_intest();
    logic seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    Mode = 2'b10; sys_in = 4'b0110; core_out = 2'b01;
    ShiftDR = 1'b1;
    for (int i = 0; i < 6; i++) begin
      TDI = seq[i];
      tick();
    end
    ShiftDR = 1'b0; UpdateDR = 1'b1;
    tick();
    UpdateDR = 1'b0;
    total_cnt++;
    if (core_in !== 4'b1001) $display("FAIL intest_core_in_a: got %b want 1001", core_in);
    else pass_cnt++;
    total_cnt++;
    if (sys_out !== 2'b01) $display("FAIL intest_sys_out_a: got %b want 01", sys_out);
    else pass_cnt++;
    sys_in = 4'b1111; core_out = 2'b10;
    #1;
    total_cnt++;
    if (core_in !== 4'b1001) $display("FAIL intest_core_in_b: got %b want 1001", core_in);
    else pass_cnt++;
    total_cnt++;
    if (sys_out !== 2'b10) $display("FAIL intest_sys_out_b: got %b want 10", sys_out);
    else pass_cnt++;
    Mode = 2'b00;
    #1;
    total_cnt++;
    if (core_in !== 4'b1111) $display("FAIL intest_to_normal: got %b want 1111", core_in);
    else pass_cnt++;
    Mode = 2'b01;
    #1;
    total_cnt++;
    if (sys_out !== 2'b00) $display("FAIL intest_up_out: got %b want 00", sys_out);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    Mode = 2'b01; ShiftDR = 1'b1; TDI = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ShiftDR = 1'b0; UpdateDR = 1'b1;
    tick();
    UpdateDR = 1'b0;
    total_cnt++;
    if (sys_out !== 2'b11) $display("FAIL arst_pre_up: got %b want 11", sys_out);
    else pass_cnt++;
    ShiftDR = 1'b1; TDI = 1'b0;
    tick();
    tick();
    #3;
    TRST = 1'b1;
    #1;
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL arst_tdo: got %b want 0", TDO);
    else pass_cnt++;
    total_cnt++;
    if (sys_out !== 2'b00) $display("FAIL arst_sys_out: got %b want 00", sys_out);
    else pass_cnt++;
    Mode = 2'b10;
    #1;
    total_cnt++;
    if (core_in !== 4'h0) $display("FAIL arst_core_in: got %h want 0", core_in);
    else pass_cnt++;
    Mode = 2'b11;
    #1;
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL arst_byp: got %b want 0", TDO);
    else pass_cnt++;
    Mode = 2'b01;
    #1;
    TRST = 1'b0;
    TDI = 1'b1;
    tick();
    TDI = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL arst_restart_early: got %b want 0", TDO);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (TDO !== 1'b1) $display("FAIL arst_restart_bit: got %b want 1", TDO);
    else pass_cnt++;
    ShiftDR = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_extest_shift();
    test_capture_shift();
    test_bypass();
    test_intest();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
